// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor: per-hart mismatch counters and persistence/no-majority FSM.
// Optional resync pulse on FAULTY entry when TMR_FAULT_MONITOR_RESYNC_EN is defined.
module tmr_fault_monitor #(
  parameter int NHARTS      = 3,
  parameter int CNT_W       = 16,
  parameter int PERSIST_THR = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    vote_valid_i,
  input  logic                    error_i,
  input  logic [NHARTS-1:0]       error_id_i,
  input  logic                    clear_i,
  input  logic                    ack_i,
  output logic [NHARTS*CNT_W-1:0] err_cnt_o,
  output logic [NHARTS-1:0]       faulty_hart_o,
  output logic                    fatal_o,
  output logic [1:0]              state_o,
  output logic                    irq_o,
  output logic                    resync_req_o
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2,
    ST_FATAL   = 2'd3
  } state_e;

  localparam logic [7:0]        THR = 8'(PERSIST_THR);
  localparam logic [NHARTS-1:0] ONE = NHARTS'(1);

  state_e            state_q, state_d;
  logic [7:0]        run_q, run_d;
  logic [NHARTS-1:0] suspect_q, suspect_d;
  logic [NHARTS-1:0] faulty_q, faulty_d;
  logic              irq_q;
  logic              id_onehot;
  logic              ev_clean, ev_single, ev_nomaj;
  logic              enter_faulty, enter_fatal;
  logic              wipe;

  assign wipe      = rst_i | clear_i;
  assign id_onehot = (|error_id_i) &
                     ~(|(error_id_i & (error_id_i - ONE)));
  assign ev_clean  = vote_valid_i & ~error_i;
  assign ev_single = vote_valid_i & error_i & id_onehot;
  assign ev_nomaj  = vote_valid_i & error_i & ~id_onehot;

  for (genvar i = 0; i < NHARTS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
      if (wipe) begin
        cnt_q <= '0;
      end else if (ev_single && error_id_i[i] && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign err_cnt_o[i*CNT_W +: CNT_W] = cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    suspect_d = suspect_q;
    faulty_d  = faulty_q;
    unique case (state_q)
      ST_OK: begin
        if (ev_nomaj) begin
          state_d = ST_FATAL;
        end else if (ev_single) begin
          suspect_d = error_id_i;
          run_d     = 8'd1;
          if (THR == 8'd1) begin
            state_d  = ST_FAULTY;
            faulty_d = error_id_i;
          end else begin
            state_d = ST_SUSPECT;
          end
        end
      end
      ST_SUSPECT: begin
        if (ev_nomaj) begin
          state_d = ST_FATAL;
        end else if (ev_single) begin
          if (error_id_i == suspect_q) begin
            run_d = run_q + 8'd1;
            if (run_q + 8'd1 == THR) begin
              state_d  = ST_FAULTY;
              faulty_d = suspect_q;
            end
          end else begin
            suspect_d = error_id_i;
            run_d     = 8'd1;
          end
        end else if (ev_clean) begin
          state_d   = ST_OK;
          run_d     = 8'd0;
          suspect_d = '0;
        end
      end
      ST_FAULTY: begin
        if (ev_nomaj) state_d = ST_FATAL;
      end
      ST_FATAL: begin
        state_d = ST_FATAL;
      end
      default: begin
        state_d = ST_FATAL;
      end
    endcase
  end

  assign enter_faulty = (state_d == ST_FAULTY) && (state_q != ST_FAULTY);
  assign enter_fatal  = (state_d == ST_FATAL) && (state_q != ST_FATAL);

  always_ff @(posedge clk_i) begin
    if (wipe) begin
      state_q   <= ST_OK;
      run_q     <= 8'd0;
      suspect_q <= '0;
      faulty_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      suspect_q <= suspect_d;
      faulty_q  <= faulty_d;
      // a fresh entry wins over a same-cycle acknowledge
      if (enter_faulty || enter_fatal) begin
        irq_q <= 1'b1;
      end else if (ack_i) begin
        irq_q <= 1'b0;
      end
    end
  end

`ifdef TMR_FAULT_MONITOR_RESYNC_EN
  logic resync_q;

  always_ff @(posedge clk_i) begin
    if (wipe) begin
      resync_q <= 1'b0;
    end else begin
      resync_q <= enter_faulty;
    end
  end

  assign resync_req_o = resync_q;
`else
  assign resync_req_o = 1'b0;
`endif

  assign state_o       = state_q;
  assign faulty_hart_o = faulty_q;
  assign fatal_o       = (state_q == ST_FATAL);
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor: default instance plus a CNT_W=2
// instance for counter saturation.
module tb_tmr_fault_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        vv, err, clr, ack;
  logic [2:0]  eid;
  logic [47:0] cnt;
  logic [2:0]  faulty;
  logic        fatal, irq, resync;
  logic [1:0]  state;

  logic        b_vv, b_err;
  logic [2:0]  b_eid;
  logic [5:0]  b_cnt;
  logic [2:0]  b_faulty;
  logic        b_fatal, b_irq, b_resync;
  logic [1:0]  b_state;

  int n_chk = 0;
  int n_err = 0;
  logic exp_rs;

  always #5 clk = ~clk;

  tmr_fault_monitor u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .vote_valid_i (vv),
    .error_i      (err),
    .error_id_i   (eid),
    .clear_i      (clr),
    .ack_i        (ack),
    .err_cnt_o    (cnt),
    .faulty_hart_o(faulty),
    .fatal_o      (fatal),
    .state_o      (state),
    .irq_o        (irq),
    .resync_req_o (resync)
  );

  tmr_fault_monitor #(.CNT_W(2)) u_sat (
    .clk_i        (clk),
    .rst_i        (rst),
    .vote_valid_i (b_vv),
    .error_i      (b_err),
    .error_id_i   (b_eid),
    .clear_i      (1'b0),
    .ack_i        (1'b0),
    .err_cnt_o    (b_cnt),
    .faulty_hart_o(b_faulty),
    .fatal_o      (b_fatal),
    .state_o      (b_state),
    .irq_o        (b_irq),
    .resync_req_o (b_resync)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [2:0] id,
                       input logic c, input logic a, input logic r);
    @(negedge clk);
    vv = v; err = e; eid = id; clr = c; ack = a; rst = r;
  endtask

  task automatic ev(input logic e, input logic [2:0] id);
    drive(1'b1, e, id, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    idle();
  endtask

  function automatic logic [15:0] c16(input int h);
    return cnt[h*16 +: 16];
  endfunction

  initial begin
`ifdef TMR_FAULT_MONITOR_RESYNC_EN
    exp_rs = 1'b1;
`else
    exp_rs = 1'b0;
`endif
    rst = 1'b1; vv = 0; err = 0; eid = 0; clr = 0; ack = 0;
    b_vv = 0; b_err = 0; b_eid = 0;
    repeat (2) @(negedge clk);
    idle();
    chk("rst_cnt", cnt[31:0], 0);
    chk("rst_cnt2", c16(2), 0);
    chk("rst_state", state, 0);
    chk("rst_irq", irq, 0);
    chk("rst_faulty", faulty, 0);
    chk("rst_fatal", fatal, 0);
    chk("rst_resync", resync, 0);

    repeat (10) ev(1'b0, 3'b000);
    idle();
    chk("clean_cnt", cnt[31:0], 0);
    chk("clean_cnt2", c16(2), 0);
    chk("clean_state", state, 0);
    chk("clean_irq", irq, 0);

    repeat (3) ev(1'b1, 3'b010);
    ev(1'b1, 3'b010);
    idle();
    chk("pers_state", state, 2);
    chk("pers_faulty", faulty, 3'b010);
    chk("pers_cnt1", c16(1), 4);
    chk("pers_irq", irq, 1);
    chk("pers_resync", resync, exp_rs);
    idle();
    chk("pers_resync_off", resync, 0);
    chk("pers_irq_hold", irq, 1);

    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    idle();
    chk("ack_irq", irq, 0);
    ev(1'b1, 3'b011);
    idle();
    chk("esc_state", state, 3);
    chk("esc_fatal", fatal, 1);
    chk("esc_irq", irq, 1);
    chk("esc_cnt1", c16(1), 4);
    chk("esc_cnt0", c16(0), 0);
    chk("esc_resync", resync, 0);
    ev(1'b1, 3'b100);
    idle();
    chk("fatal_cnt2", c16(2), 1);
    chk("fatal_stay", state, 3);

    do_clear();
    chk("clr_state", state, 0);
    chk("clr_cnt", cnt, 0);
    chk("clr_fatal", fatal, 0);
    chk("clr_irq", irq, 0);

    ev(1'b1, 3'b001); ev(1'b1, 3'b001); ev(1'b0, 3'b000);
    ev(1'b1, 3'b001); ev(1'b1, 3'b001); ev(1'b1, 3'b001);
    idle();
    chk("run_state", state, 1);
    chk("run_cnt0", c16(0), 5);
    chk("run_irq", irq, 0);
    ev(1'b1, 3'b001);
    idle();
    chk("run4_state", state, 2);
    chk("run4_faulty", faulty, 3'b001);
    chk("run4_cnt0", c16(0), 6);

    do_clear();
    ev(1'b1, 3'b001);
    idle();
    chk("sus_state", state, 1);
    drive(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    idle();
    chk("clrev_state", state, 0);
    chk("clrev_cnt0", c16(0), 0);
    chk("clrev_faulty", faulty, 0);
    chk("clrev_irq", irq, 0);
    chk("clrev_resync", resync, 0);
    repeat (3) ev(1'b1, 3'b001);
    idle();
    chk("clrev_run", state, 1);
    ev(1'b1, 3'b001);
    idle();
    chk("clrev_run4", state, 2);

    do_clear();
    repeat (3) ev(1'b1, 3'b100);
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    ev(1'b1, 3'b100);
    idle();
    chk("rstmid_state", state, 1);
    chk("rstmid_cnt2", c16(2), 1);

    do_clear();
    repeat (3) ev(1'b1, 3'b010);
    drive(1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
    idle();
    chk("ackent_state", state, 2);
    chk("ackent_irq", irq, 1);

    do_clear();
    ev(1'b1, 3'b000);
    idle();
    chk("nomaj0_state", state, 3);
    chk("nomaj0_cnt", cnt, 0);

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      b_vv = 1'b1; b_err = 1'b1;
      b_eid = (i % 2 == 0) ? 3'b100 : 3'b001;
      if (i == 5) chk("sat_cnt2_3hits", b_cnt[5:4], 3);
    end
    @(negedge clk);
    b_vv = 1'b0; b_err = 1'b0; b_eid = 3'b000;
    chk("sat_cnt2_nowrap", b_cnt[5:4], 3);
    chk("sat_cnt0", b_cnt[1:0], 3);
    chk("sat_state", b_state, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
